// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: 14-bit unsigned binary to five packed BCD digits.
// Define BCD_BLANK_EN to add the registered leading-zero mask output `blank`.
module binary_to_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done
`ifdef BCD_BLANK_EN
  ,
  output logic [4:0]  blank
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [19:0] acc_q, acc_d;
  logic [13:0] op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] adj_s;
`ifdef BCD_BLANK_EN
  logic [4:0]  blank_q, blank_d;
`endif

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  function automatic logic [19:0] dabble_adjust(input logic [19:0] acc);
    logic [19:0] r;
    r = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef BCD_BLANK_EN
  // Bit i set when digit i and every higher digit are zero; units is never blanked.
  function automatic logic [4:0] blank_mask(input logic [19:0] d);
    logic [4:0] m;
    m[4] = (d[19:16] == 4'd0);
    m[3] = m[4] && (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  assign adj_s = dabble_adjust(acc_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = bin;
          acc_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        {acc_d, op_d} = {adj_s[18:0], op_q, 1'b0};
        if (cnt_q == 4'd13) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        bcd_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef BCD_BLANK_EN
        blank_d = blank_mask(acc_q);
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset wins over start and discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= 20'd0;
      op_q    <= 14'd0;
      cnt_q   <= 4'd0;
      bcd_q   <= 20'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q <= 5'b11110;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: directed corner cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_binary_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [19:0] bcd;
  logic        busy;
  logic        done;
`ifdef BCD_BLANK_EN
  logic [4:0]  blank;
`endif

  int errors = 0;
  int checks = 0;
  logic [19:0] last_bcd;

  binary_to_bcd dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
`ifdef BCD_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = 20'd0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int unsigned v);
    logic [4:0] m;
    int unsigned p;
    m = 5'b00000;
    p = 1;
    for (int i = 1; i < 5; i++) begin
      p = p * 10;
      m[i] = (v < p);
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: start at edge N, done expected at N+15, idle again at N+16.
  task automatic convert(input logic [13:0] v);
    int busy_cnt;
    int early_done;
    int hold_bad;
    bin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin = 14'($urandom);
    busy_cnt = 0;
    early_done = 0;
    hold_bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) early_done++;
      if (bcd !== last_bcd) hold_bad++;
    end
    check("busy_cycles", busy_cnt, 15);
    check("no_early_done", early_done, 0);
    check("bcd_held", hold_bad, 0);
    tick();
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    check("bcd_value", {12'd0, bcd}, {12'd0, ref_bcd(v)});
`ifdef BCD_BLANK_EN
    check("blank_value", {27'd0, blank}, {27'd0, ref_blank(v)});
`endif
    last_bcd = ref_bcd(v);
    tick();
    check("done_falls", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dcount;
    int dfirst;
    int dlast;
    int gap_bad;
    int val_bad;
    logic [19:0] dbcd;

    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    bin = 14'd0;
    last_bcd = 20'd0;

    // Reset state, with start asserted to show reset priority.
    start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef BCD_BLANK_EN
    check("rst_blank", {27'd0, blank}, 32'h1e);
`endif
    tick();

    // Directed corner operands.
    convert(14'd0);
    convert(14'd9999);
    convert(14'd16383);
    convert(14'd10);
    convert(14'd42);
    convert(14'd10000);

    // Random operands.
    for (int n = 0; n < 20; n++) begin
      convert(14'($urandom_range(0, 16383)));
    end

    // Second start during conversion is ignored.
    bin = 14'd123;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    dfirst = 0;
    dbcd = 20'd0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        bin = 14'd456;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        dcount++;
        dfirst = k;
        dbcd = bcd;
      end
    end
    check("ignore_start_pulses", dcount, 1);
    check("ignore_start_edge", dfirst, 15);
    check("ignore_start_bcd", {12'd0, dbcd}, {12'd0, ref_bcd(123)});
    last_bcd = ref_bcd(123);

    // Reset mid-conversion aborts it.
    bin = 14'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {12'd0, bcd}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 0);
    last_bcd = 20'd0;
    convert(14'd7);

    // Held start: back-to-back conversions every 16 cycles.
    bin = 14'd42;
    start = 1'b1;
    tick();
    dcount = 0;
    dfirst = 0;
    dlast = 0;
    gap_bad = 0;
    val_bad = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (done === 1'b1) begin
        if (dcount == 0) dfirst = k;
        else if (k - dlast != 16) gap_bad++;
        if (bcd !== ref_bcd(42)) val_bad++;
        dlast = k;
        dcount++;
      end
    end
    start = 1'b0;
    check("held_pulses", dcount, 4);
    check("held_first", dfirst, 15);
    check("held_gap", gap_bad, 0);
    check("held_bcd", val_bad, 0);
    for (int k = 0; k < 20; k++) tick();
    check("held_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd.md
BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port `clk`, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port `start`, input, 1 bit: conversion request, sampled on each rising edge.
REQ-005 SHALL have port `bin`, input, 14 bits: unsigned binary operand, range 0..16383, sampled only when a start is accepted.
REQ-006 SHALL have port `bcd`, output, 20 bits: five packed BCD digits; [3:0] is units, [19:16] is ten-thousands.
REQ-007 SHALL have port `busy`, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port `done`, output, 1 bit: one-cycle pulse marking a new valid `bcd`.
REQ-009 SHALL have port `blank`, output, 5 bits, present only with BCD_BLANK_EN: leading-zero mask, bit i covers digit i.

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 SHALL, in IDLE with start=1 at edge N, capture `bin` into the shift register, clear the BCD accumulator and the iteration counter, and enter SHIFT.
REQ-012 SHALL, in SHIFT, perform one double-dabble step per cycle: add 3 to each 4-bit accumulator digit that is >=5, then shift {accumulator, operand} left by one bit.
REQ-013 SHALL perform exactly 14 SHIFT cycles, from edge N+1 through edge N+14, then enter DONE.
REQ-014 SHALL load `bcd` from the accumulator and set done=1 at edge N+15 (DONE state); `done` SHALL fall at edge N+16 on return to IDLE.
REQ-015 SHALL drive busy=1 in SHIFT and DONE, and busy=0 only in IDLE.
REQ-016 SHALL hold `bcd` stable from one completion until the next completion; starting a conversion SHALL NOT clear it.
REQ-017 SHALL ignore `start` while busy=1, including the DONE cycle; no queuing.
REQ-018 SHALL accept a start asserted in the first IDLE cycle after DONE, so back-to-back conversions take 16 cycles each.
REQ-019 SHALL ignore changes on `bin` after capture.
REQ-020 SHALL produce every output digit in the range 0..9; the full input range SHALL convert without overflow, with maximum 16383 giving 0x16383.
REQ-021 SHALL give held `start` no extra meaning: a start held high through DONE begins a new conversion in the following IDLE cycle.

Reset
REQ-022 SHALL, with reset=1 at a rising edge, set state=IDLE, bcd=0, busy=0, done=0, counter=0 and accumulator=0, and with BCD_BLANK_EN set blank=5'b11110.
REQ-023 SHALL take priority over `start`.
REQ-024 SHALL, if asserted mid-conversion, abort that conversion, produce no done pulse, and leave bcd=0.

Configuration
REQ-025 SHALL use macro BCD_BLANK_EN.
REQ-026 SHALL, with BCD_BLANK_EN defined, provide port `blank` as a registered output updated in the same cycle as `bcd`: bit i=1 when digit i and all higher digits are zero, for i in 1..4; bit 0 SHALL always be 0.
REQ-027 SHALL, without BCD_BLANK_EN, omit port `blank` and its logic; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: reset, then start with bin=0 -> busy high for 15 cycles, done pulses at edge N+15, bcd=0x00000.
REQ-029 SHALL cover: bin=9999 -> bcd=0x09999; bin=16383 -> bcd=0x16383; bin=10 -> bcd=0x00010.
REQ-030 SHALL cover: start with bin=123, then start with bin=456 at N+5 -> second start ignored, bcd=0x00123, exactly one done pulse.
REQ-031 SHALL cover: start with bin=500, reset at N+7 -> no done pulse, bcd=0, busy=0 at the next edge; a new start with bin=7 gives 0x00007.
REQ-032 SHALL cover: start held high continuously with bin=42 -> done pulses every 16 cycles, bcd=0x00042 each time.
REQ-033 SHALL cover, with BCD_BLANK_EN: bin=42 -> blank=5'b11100; bin=0 -> blank=5'b11110; bin=10000 -> blank=5'b00000.
